huff_stream_packer: RTL
=======================

// Module: huff_stream_packer
// PURPOSE
// - Downstream stage of the Huffman encoder.
// - Captures the serialized code table the encoder emits as alternating words:
//   {done,char[7:0]} followed by {done,2'b0,mask[2:0],value[2:0]}.
// - Then encodes a handshaked symbol stream into an MSB-first packed byte stream.
// - On frame end, flushes the final partial byte, zero-padded.
// PARAMETERS
// - NUM_SYMS  3  table entries captured per load; matches the encoder character count.
// - CODE_W    3  max code length and mask/value width.
// - OUT_W     8  packed output word width.
// PORTS
// - clk        in   1       clock
// - reset      in   1       synchronous, active-high
// - reload     in   1       pulse: clear table/accumulator, return to LOAD
// - tbl_in     in   9       encoder output word; bit8 = done flag
// - tbl_valid  in   1       tbl_in qualifier; word accepted only if tbl_valid && tbl_in[8]
// - sym_in     in   8       ASCII symbol to encode
// - sym_valid  in   1       symbol handshake valid
// - sym_last   in   1       marks last symbol of frame (qualified by sym_valid)
// - sym_ready  out  1       symbol handshake ready
// - out_data   out  OUT_W   packed bits, first code bit in MSB
// - out_bits   out  4       number of valid bits in out_data (1..OUT_W)
// - out_last   out  1       final word of frame
// - out_valid  out  1       output handshake valid
// - out_ready  in   1       output handshake ready
// - tbl_loaded out  1       high when table is complete (state != LOAD)
// - err_miss   out  1       sticky: symbol not found in table; cleared by reset/reload
// BEHAVIOUR
// - Reset: state=LOAD; table, acc, acc_cnt, entry index, word phase = 0.
//   All outputs 0 (sym_ready=0, out_valid=0, err_miss=0).
// - Accumulator: width OUT_W+CODE_W-1 (10 bits), left-aligned; acc_cnt is 4 bits.
// - LOAD:
//   - Phase 0 word stores char=tbl_in[7:0]; phase 1 word stores mask=tbl_in[5:3], value=tbl_in[2:0].
//   - The entry index advances after the phase-1 word.
//   - After entry NUM_SYMS-1 is completed -> RUN (registered; tbl_loaded rises the next cycle).
//   - sym_ready=0 in LOAD; tbl_in is ignored outside LOAD.
// - Lookup (combinational):
//   - First matching entry (lowest index) wins.
//   - len = popcount(mask); code = value[len-1:0], sent MSB-first.
//   - len=0 -> symbol consumed, no bits appended.
// - RUN:
//   - sym_ready = (acc_cnt < OUT_W) && !out_valid.
//   - Accept (sym_valid&&sym_ready): append code below the current acc_cnt bits; acc_cnt += len.
//   - Miss: err_miss<=1, symbol consumed, nothing appended.
//   - If acc_cnt >= OUT_W: out_valid=1, out_data=acc top OUT_W bits, out_bits=OUT_W, out_last=0.
//   - On out handshake: acc <<= OUT_W, acc_cnt -= OUT_W.
//   - Symbol accept and output pop are never in the same cycle (guaranteed by the sym_ready rule).
//   - out_data, out_bits and out_last are held stable while out_valid && !out_ready.
//   - Accepted symbol with sym_last=1 -> FLUSH, after its code is appended.
// - FLUSH:
//   - sym_ready=0.
//   - While acc_cnt > OUT_W: emit full words with out_last=0.
//   - When 0 < acc_cnt <= OUT_W: emit the word zero-padded, out_bits=acc_cnt, out_last=1.
//     On handshake: acc=0, acc_cnt=0 -> RUN.
//   - acc_cnt==0 on FLUSH entry: emit out_data=0, out_bits=0, out_last=1 so the frame always terminates.
//   - The table is retained across frames.
// - reload:
//   - Accepted in any state; takes priority over all other activity that cycle.
//   - Same effect as reset except no other register behaviour differs.
//   - Any word in flight is dropped.
// - Reset mid-frame: immediate return to reset state; no flush.
// STRUCTURE
// - Package huff_pkg holds:
//   - localparams CODE_W, OUT_W, NUM_SYMS.
//   - typedef code_entry_t {logic [7:0] ch; logic [CODE_W-1:0] mask, value;}.
//   - enum pk_state_t {LOAD, RUN, FLUSH}.
// - Sub-module huff_code_lookup (combinational):
//   - Inputs: entries[NUM_SYMS], sym.
//   - Outputs: hit, len[1:0], code[CODE_W-1:0].
// - The top module holds the FSM, accumulator and handshakes.
// TESTING
// - Table load: a=0x61 m=001 v=000, b=0x62 m=011 v=010, c=0x63 m=011 v=011.
//   Stream a,b,c,a,b,c(last) -> 0x5A bits=8 last=0, then 0xC0 bits=2 last=1.
// - Backpressure: hold out_ready=0 for 5 cycles with acc_cnt >= 8 -> sym_ready=0, out_* stable.
//   Release -> single pop, then stream resumes unchanged.
// - Exact fill: eight 'a' with last on the 8th -> one word 0x00 bits=8 last=1; no extra word.
// - Miss: insert 0x7A mid-stream -> err_miss=1 (sticky), no bits added.
//   Surrounding packed bytes match the stream without 0x7A.
// - Empty flush: only symbol 0x7A with last -> err_miss=1; one word data=0 bits=0 last=1; back to RUN.
// - Reset/reload: assert reset mid-frame -> all outputs 0, tbl_loaded=0.
//   Pulse reload in RUN -> LOAD, err_miss cleared; a new table load succeeds.

Source files
------------

// File: rtl/huff_stream_packer_pkg.sv
// Shared types and sizing for the Huffman stream packer.
// The code table entry layout mirrors the two-word serialization the encoder emits.
package huff_pkg;
   localparam int CODE_W   = 3;
   localparam int OUT_W    = 8;
   localparam int NUM_SYMS = 3;
   localparam int ACC_W    = OUT_W + CODE_W - 1;

   typedef struct packed {
      logic [7:0]        ch;
      logic [CODE_W-1:0] mask;
      logic [CODE_W-1:0] value;
   } code_entry_t;

   typedef enum logic [1:0] {LOAD, RUN, FLUSH} pk_state_t;

   function automatic logic [1:0] popcount_mask(input logic [CODE_W-1:0] m);
      logic [1:0] n;
      n = '0;
      for (int i = 0; i < CODE_W; i++) n = n + 2'(m[i]);
      return n;
   endfunction
endpackage

// File: rtl/huff_stream_packer_lookup.sv
// Combinational symbol-to-code lookup; the lowest-index matching entry wins.
// The code is returned right-aligned, with len bits valid.
module huff_code_lookup
   import huff_pkg::*;
(
   input  code_entry_t       entries [NUM_SYMS],
   input  logic [7:0]        sym,
   output logic              hit,
   output logic [1:0]        len,
   output logic [CODE_W-1:0] code
);

   // Walk from the top so the lowest index overwrites any later match.
   always_comb begin
      hit  = 1'b0;
      len  = '0;
      code = '0;
      for (int i = NUM_SYMS - 1; i >= 0; i--) begin
         if (entries[i].ch == sym) begin
            hit  = 1'b1;
            len  = popcount_mask(entries[i].mask);
            code = entries[i].value & ~({CODE_W{1'b1}} << popcount_mask(entries[i].mask));
         end
      end
   end

endmodule

// File: rtl/huff_stream_packer.sv
// Captures the encoder code table, then packs symbol codes MSB-first into OUT_W-bit words.
// state | meaning: LOAD = capturing table words, RUN = packing symbols, FLUSH = draining frame tail
module huff_stream_packer
   import huff_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             reload,
   input  logic [8:0]       tbl_in,
   input  logic             tbl_valid,
   input  logic [7:0]       sym_in,
   input  logic             sym_valid,
   input  logic             sym_last,
   output logic             sym_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [3:0]       out_bits,
   output logic             out_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             tbl_loaded,
   output logic             err_miss
);

   pk_state_t         state, nxt_state;
   code_entry_t       entries [NUM_SYMS];
   code_entry_t       nxt_entries [NUM_SYMS];
   logic [ACC_W-1:0]  acc, nxt_acc, code_al;
   logic [3:0]        acc_cnt, nxt_cnt;
   logic [1:0]        idx, nxt_idx;
   logic              phase, nxt_phase, nxt_err;
   logic              hit;
   logic [1:0]        len;
   logic [CODE_W-1:0] code;
   logic              sym_acc, pop;
   logic              nxt_ov, nxt_last, nxt_ready;
   logic [OUT_W-1:0]  nxt_data;
   logic [3:0]        nxt_bits;

   huff_code_lookup u_lookup (
      .entries (entries),
      .sym     (sym_in),
      .hit     (hit),
      .len     (len),
      .code    (code)
   );

   // Left-align the code in the accumulator frame, then slot it under the bits already held.
   assign code_al = {code, {(ACC_W-CODE_W){1'b0}}} << (2'(CODE_W) - len);
   assign sym_acc = sym_valid && sym_ready;
   assign pop     = out_valid && out_ready;

   always_comb begin
      nxt_state   = state;
      nxt_entries = entries;
      nxt_acc     = acc;
      nxt_cnt     = acc_cnt;
      nxt_idx     = idx;
      nxt_phase   = phase;
      nxt_err     = err_miss;
      case (state)
         LOAD: begin
            if (tbl_valid && tbl_in[8]) begin
               if (!phase) begin
                  nxt_entries[idx].ch = tbl_in[7:0];
                  nxt_phase           = 1'b1;
               end else begin
                  nxt_entries[idx].mask  = tbl_in[5:3];
                  nxt_entries[idx].value = tbl_in[2:0];
                  nxt_phase              = 1'b0;
                  if (idx == 2'(NUM_SYMS - 1)) begin
                     nxt_idx   = '0;
                     nxt_state = RUN;
                  end else begin
                     nxt_idx = idx + 2'd1;
                  end
               end
            end
         end
         RUN: begin
            if (sym_acc) begin
               if (hit) begin
                  nxt_acc = acc | (code_al >> acc_cnt);
                  nxt_cnt = acc_cnt + 4'(len);
               end else begin
                  nxt_err = 1'b1;
               end
               if (sym_last) nxt_state = FLUSH;
            end else if (pop) begin
               nxt_acc = acc << OUT_W;
               nxt_cnt = acc_cnt - 4'(OUT_W);
            end
         end
         FLUSH: begin
            if (pop) begin
               if (acc_cnt > 4'(OUT_W)) begin
                  nxt_acc = acc << OUT_W;
                  nxt_cnt = acc_cnt - 4'(OUT_W);
               end else begin
                  nxt_acc   = '0;
                  nxt_cnt   = '0;
                  nxt_state = RUN;
               end
            end
         end
         default: nxt_state = LOAD;
      endcase
   end

   // Handshake outputs are registered from the next-state view so they line up with acc/acc_cnt.
   always_comb begin
      nxt_ov    = (nxt_state == FLUSH) || ((nxt_state == RUN) && (nxt_cnt >= 4'(OUT_W)));
      nxt_last  = (nxt_state == FLUSH) && (nxt_cnt <= 4'(OUT_W));
      nxt_data  = nxt_ov ? nxt_acc[ACC_W-1 -: OUT_W] : '0;
      nxt_bits  = !nxt_ov ? 4'd0 : (nxt_last ? nxt_cnt : 4'(OUT_W));
      nxt_ready = (nxt_state == RUN) && (nxt_cnt < 4'(OUT_W)) && !nxt_ov;
   end

   always_ff @(posedge clk) begin
      if (reset || reload) begin
         state      <= LOAD;
         for (int i = 0; i < NUM_SYMS; i++) entries[i] <= '0;
         acc        <= '0;
         acc_cnt    <= '0;
         idx        <= '0;
         phase      <= 1'b0;
         err_miss   <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_bits   <= '0;
         out_last   <= 1'b0;
         sym_ready  <= 1'b0;
         tbl_loaded <= 1'b0;
      end else begin
         state      <= nxt_state;
         entries    <= nxt_entries;
         acc        <= nxt_acc;
         acc_cnt    <= nxt_cnt;
         idx        <= nxt_idx;
         phase      <= nxt_phase;
         err_miss   <= nxt_err;
         out_valid  <= nxt_ov;
         out_data   <= nxt_data;
         out_bits   <= nxt_bits;
         out_last   <= nxt_ov && nxt_last;
         sym_ready  <= nxt_ready;
         tbl_loaded <= (nxt_state != LOAD);
      end
   end

endmodule
